// File: rtl/hilo_div_unit_pkg.sv
// -----------------------------------------------------------------------------
// hilo_div_unit_pkg
// Shared definitions for the HI/LO register pair and iterative divider:
//   - div_state_e : divider FSM state encoding (IDLE / RUN / DONE)
//   - DIV_CYCLES  : number of restoring steps performed per division
// -----------------------------------------------------------------------------
package hilo_div_unit_pkg;

    localparam int DIV_CYCLES = 32;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_RUN  = 2'b01,
        DIV_DONE = 2'b10
    } div_state_e;

endpackage

// File: rtl/hilo_div_unit_if.sv
// -----------------------------------------------------------------------------
// hilo_div_unit_if
// Pipeline <-> HI/LO unit connection.
//   master : pipeline side (drives write requests, divide requests, flush)
//   slave  : hilo_div_unit side (drives hi_out/lo_out, div_busy, div_done)
// Signals:
//   we_hi/we_lo, hi_wdata/lo_wdata : ALU-path HI/LO writes at writeback
//   div_start/div_signed/div_a/div_b : divide request, sampled in IDLE
//   flush                            : aborts a running division
//   hi_out/lo_out                    : HI/LO read operands for the ALU
//   div_busy                         : pipeline stall request
//   div_done                         : one-cycle completion pulse
// -----------------------------------------------------------------------------
interface hilo_div_unit_if #(
    parameter int WIDTH = 32
);
    logic             we_hi;
    logic             we_lo;
    logic [WIDTH-1:0] hi_wdata;
    logic [WIDTH-1:0] lo_wdata;
    logic             div_start;
    logic             div_signed;
    logic [WIDTH-1:0] div_a;
    logic [WIDTH-1:0] div_b;
    logic             flush;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    logic             div_busy;
    logic             div_done;

    modport master (
        output we_hi, we_lo, hi_wdata, lo_wdata,
        output div_start, div_signed, div_a, div_b, flush,
        input  hi_out, lo_out, div_busy, div_done
    );

    modport slave (
        input  we_hi, we_lo, hi_wdata, lo_wdata,
        input  div_start, div_signed, div_a, div_b, flush,
        output hi_out, lo_out, div_busy, div_done
    );
endinterface

// File: rtl/hilo_div_unit_div_core.sv
// -----------------------------------------------------------------------------
// hilo_div_unit_div_core
// Unsigned restoring shift/subtract divider datapath with step counter.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   start               : load dividend/divisor magnitudes, clear counter
//   step                : perform one restoring step this cycle
//   flush               : abandon the division (counter back to 0)
//   dividend, divisor   : operand magnitudes
//   quotient, remainder : magnitude results (valid after the last step)
//   last                : the current step is the final one
// A zero divisor never borrows, so the quotient fills with ones and the
// remainder ends up holding the dividend.
// -----------------------------------------------------------------------------
module hilo_div_unit_div_core
    import hilo_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step,
    input  logic             flush,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             last
);
    localparam int             CNT_W    = $clog2(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] div_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH:0]   shift_s;
    logic [WIDTH:0]   trial_s;
    logic             fits_s;

    // One restoring step: shift next dividend bit into the partial remainder and trial-subtract.
    always_comb begin
        shift_s = {rem_r, quo_r[WIDTH-1]};
        trial_s = shift_s - {1'b0, div_r};
        fits_s  = (shift_s >= {1'b0, div_r});
    end

    // Datapath and step counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_r <= '0;
            quo_r <= '0;
            div_r <= '0;
            cnt_r <= '0;
        end else if (start) begin
            rem_r <= '0;
            quo_r <= dividend;
            div_r <= divisor;
            cnt_r <= '0;
        end else if (flush) begin
            cnt_r <= '0;
        end else if (step) begin
            if (fits_s) begin
                rem_r <= trial_s[WIDTH-1:0];
                quo_r <= {quo_r[WIDTH-2:0], 1'b1};
            end else begin
                rem_r <= shift_s[WIDTH-1:0];
                quo_r <= {quo_r[WIDTH-2:0], 1'b0};
            end
            cnt_r <= cnt_r + CNT_ONE;
        end
    end

    assign quotient  = quo_r;
    assign remainder = rem_r;
    assign last      = (cnt_r == CNT_LAST);

endmodule

// File: rtl/hilo_div_unit.sv
// -----------------------------------------------------------------------------
// hilo_div_unit
// Architectural HI/LO register pair plus iterative DIV/DIVU unit.
// Ports:
//   clk  : core clock, rising edge
//   rst  : asynchronous active-high reset
//   bus  : hilo_div_unit_if.slave (ALU writes, divide requests, flush,
//          hi_out/lo_out read operands, div_busy stall, div_done pulse)
// The divider writes HI = remainder, LO = quotient at the edge closing its
// DONE cycle; that write beats a same-cycle ALU write.
// Build option HILO_BYPASS_EN: when defined, hi_out/lo_out forward the
// value being written this cycle (divider result first, then ALU data);
// when undefined they show the registered HI/LO only.
// -----------------------------------------------------------------------------
module hilo_div_unit
    import hilo_div_unit_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    hilo_div_unit_if.slave bus
);
    localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

    div_state_e       state_r;
    div_state_e       state_nxt_s;
    logic             qsign_r;
    logic             rsign_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             load_s;
    logic             step_s;
    logic             last_s;
    logic             done_wr_s;
    logic             busy_s;
    logic [WIDTH-1:0] a_mag_s;
    logic [WIDTH-1:0] b_mag_s;
    logic [WIDTH-1:0] quo_s;
    logic [WIDTH-1:0] rem_s;
    logic [WIDTH-1:0] quo_fix_s;
    logic [WIDTH-1:0] rem_fix_s;

    // Operand magnitudes; the most negative value maps onto itself, which is its correct unsigned magnitude.
    always_comb begin
        a_mag_s = bus.div_a;
        b_mag_s = bus.div_b;
        if (bus.div_signed && bus.div_a[WIDTH-1]) begin
            a_mag_s = ~bus.div_a + ONE_W;
        end else begin
            a_mag_s = bus.div_a;
        end
        if (bus.div_signed && bus.div_b[WIDTH-1]) begin
            b_mag_s = ~bus.div_b + ONE_W;
        end else begin
            b_mag_s = bus.div_b;
        end
    end

    hilo_div_unit_div_core #(
        .WIDTH (WIDTH)
    ) u_div_core (
        .clk       (clk),
        .rst       (rst),
        .start     (load_s),
        .step      (step_s),
        .flush     (bus.flush),
        .dividend  (a_mag_s),
        .divisor   (b_mag_s),
        .quotient  (quo_s),
        .remainder (rem_s),
        .last      (last_s)
    );

    // Divider FSM next state and control; busy is combinational so DIV stalls in its own issue cycle.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        step_s      = 1'b0;
        done_wr_s   = 1'b0;
        busy_s      = 1'b0;
        case (state_r)
            DIV_IDLE: begin
                busy_s = bus.div_start;
                if (bus.div_start && !bus.flush) begin
                    state_nxt_s = DIV_RUN;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = DIV_IDLE;
                end
            end
            DIV_RUN: begin
                busy_s = 1'b1;
                if (bus.flush) begin
                    state_nxt_s = DIV_IDLE;
                end else begin
                    step_s = 1'b1;
                    if (last_s) begin
                        state_nxt_s = DIV_DONE;
                    end else begin
                        state_nxt_s = DIV_RUN;
                    end
                end
            end
            DIV_DONE: begin
                state_nxt_s = DIV_IDLE;
                if (bus.flush) begin
                    done_wr_s = 1'b0;
                end else begin
                    done_wr_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s = DIV_IDLE;
            end
        endcase
    end

    // Divider FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= DIV_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Result signs captured with the operands; unsigned divides never negate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            qsign_r <= 1'b0;
            rsign_r <= 1'b0;
        end else if (load_s) begin
            qsign_r <= bus.div_signed & (bus.div_a[WIDTH-1] ^ bus.div_b[WIDTH-1]);
            rsign_r <= bus.div_signed & bus.div_a[WIDTH-1];
        end
    end

    // Sign fixups applied to the magnitude results during DONE.
    always_comb begin
        quo_fix_s = quo_s;
        rem_fix_s = rem_s;
        if (qsign_r) begin
            quo_fix_s = ~quo_s + ONE_W;
        end else begin
            quo_fix_s = quo_s;
        end
        if (rsign_r) begin
            rem_fix_s = ~rem_s + ONE_W;
        end else begin
            rem_fix_s = rem_s;
        end
    end

    // HI/LO registers: divider completion first, otherwise independent ALU writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi_r <= '0;
            lo_r <= '0;
        end else if (done_wr_s) begin
            hi_r <= rem_fix_s;
            lo_r <= quo_fix_s;
        end else begin
            if (bus.we_hi) begin
                hi_r <= bus.hi_wdata;
            end
            if (bus.we_lo) begin
                lo_r <= bus.lo_wdata;
            end
        end
    end

    // Read operands, optionally forwarding this cycle's write data.
    always_comb begin
`ifdef HILO_BYPASS_EN
        bus.hi_out = hi_r;
        bus.lo_out = lo_r;
        if (done_wr_s) begin
            bus.hi_out = rem_fix_s;
            bus.lo_out = quo_fix_s;
        end else begin
            if (bus.we_hi) begin
                bus.hi_out = bus.hi_wdata;
            end else begin
                bus.hi_out = hi_r;
            end
            if (bus.we_lo) begin
                bus.lo_out = bus.lo_wdata;
            end else begin
                bus.lo_out = lo_r;
            end
        end
`else
        bus.hi_out = hi_r;
        bus.lo_out = lo_r;
`endif
    end

    assign bus.div_busy = busy_s;
    assign bus.div_done = done_wr_s;

endmodule

// File: tb/tb_hilo_div_unit.sv
// -----------------------------------------------------------------------------
// tb_hilo_div_unit
// Self-checking bench for hilo_div_unit: a table of directed divides, hand
// sequences for reset/flush/priority/timing corners, and random divides and
// writes checked against an arithmetic reference model. Works with or without
// HILO_BYPASS_EN defined.
// -----------------------------------------------------------------------------
module tb_hilo_div_unit;

    typedef struct {
        bit          sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
    } vec_t;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [31:0] mhi;
    logic [31:0] mlo;
    vec_t tbl[11];

    hilo_div_unit_if #(.WIDTH(32)) bus ();

    hilo_div_unit #(.WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: plain integer division with the documented corner rules.
    function automatic void ref_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] q, output logic [31:0] r);
        int sa;
        int sb;
        if (b == 32'd0) begin
            r = a;
            q = (sgn && a[31]) ? 32'h0000_0001 : 32'hFFFF_FFFF;
        end else if (!sgn) begin
            q = a / b;
            r = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 32'h0000_0000;
        end else begin
            sa = a;
            sb = b;
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end
    endfunction

    task automatic run_div(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_q, input logic [31:0] exp_r,
                           input int flush_at, input int restart_at, input bit we_lo_done);
        int edges;
        bit busy_ok;
        bit flushed;
        bit saw_done;
        @(posedge clk); #1;
        bus.div_start  = 1'b1;
        bus.div_signed = sgn;
        bus.div_a      = a;
        bus.div_b      = b;
        #1;
        chk("busy_on_start", 32'(bus.div_busy), 32'd1);
        @(posedge clk); #1;
        bus.div_start = 1'b0;
        bus.div_a     = $urandom;
        bus.div_b     = $urandom;
        edges    = 0;
        busy_ok  = 1'b1;
        flushed  = 1'b0;
        saw_done = 1'b0;
        while (!saw_done && edges < 40) begin
            @(posedge clk); #1;
            edges++;
            bus.flush     = 1'b0;
            bus.div_start = 1'b0;
            if (edges == flush_at) begin
                bus.flush = 1'b1;
                flushed   = 1'b1;
            end
            if (edges == restart_at) begin
                bus.div_start = 1'b1;
                bus.div_a     = 32'h0000_FFFF;
                bus.div_b     = 32'h0000_0003;
            end
            #1;
            if (bus.div_done) begin
                saw_done = 1'b1;
            end else if (!flushed && edges < 32 && !bus.div_busy) begin
                busy_ok = 1'b0;
            end
        end
        bus.flush     = 1'b0;
        bus.div_start = 1'b0;
        if (flush_at < 0) begin
            chk("done_latency", 32'(edges), 32'd32);
            chk("busy_in_run", 32'(busy_ok), 32'd1);
            chk("busy_in_done", 32'(bus.div_busy), 32'd0);
            if (we_lo_done) begin
                bus.we_lo    = 1'b1;
                bus.lo_wdata = 32'h0000_0005;
                #1;
`ifdef HILO_BYPASS_EN
                chk("done_fwd_lo", bus.lo_out, exp_q);
                chk("done_fwd_hi", bus.hi_out, exp_r);
`else
                chk("done_hold_lo", bus.lo_out, mlo);
                chk("done_hold_hi", bus.hi_out, mhi);
`endif
            end
            @(posedge clk); #1;
            bus.we_lo = 1'b0;
            #1;
            chk("done_pulse_end", 32'(bus.div_done), 32'd0);
            mlo = exp_q;
            mhi = exp_r;
            chk("div_lo", bus.lo_out, mlo);
            chk("div_hi", bus.hi_out, mhi);
        end else begin
            chk("flush_no_done", 32'(saw_done), 32'd0);
            chk("flush_busy", 32'(bus.div_busy), 32'd0);
            chk("flush_lo", bus.lo_out, mlo);
            chk("flush_hi", bus.hi_out, mhi);
        end
    endtask

    initial begin
        logic [31:0] q;
        logic [31:0] r;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        bit          sgn;
        bit          seen;

        checks = 0;
        errors = 0;
        mhi    = 32'd0;
        mlo    = 32'd0;

        tbl[0]  = '{1'b0, 32'h0000_0007, 32'h0000_0002, 32'h0000_0003, 32'h0000_0001};
        tbl[1]  = '{1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
        tbl[2]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'h0000_0000};
        tbl[3]  = '{1'b0, 32'h0000_1234, 32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_1234};
        tbl[4]  = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'h0000_0001};
        tbl[5]  = '{1'b1, 32'hFFFF_FFF9, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFF9};
        tbl[6]  = '{1'b0, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000};
        tbl[7]  = '{1'b0, 32'h0000_0005, 32'h0000_0007, 32'h0000_0000, 32'h0000_0005};
        tbl[8]  = '{1'b1, 32'h8000_0000, 32'h0000_0001, 32'h8000_0000, 32'h0000_0000};
        tbl[9]  = '{1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
        tbl[10] = '{1'b1, 32'hFFFF_FFF0, 32'hFFFF_FFFD, 32'h0000_0005, 32'hFFFF_FFFF};

        bus.we_hi = 1'b0; bus.we_lo = 1'b0;
        bus.hi_wdata = 32'd0; bus.lo_wdata = 32'd0;
        bus.div_start = 1'b0; bus.div_signed = 1'b0;
        bus.div_a = 32'd0; bus.div_b = 32'd0; bus.flush = 1'b0;

        // Reset state
        rst = 1'b1;
        #12;
        chk("rst_hi", bus.hi_out, 32'd0);
        chk("rst_lo", bus.lo_out, 32'd0);
        chk("rst_busy", 32'(bus.div_busy), 32'd0);
        chk("rst_done", 32'(bus.div_done), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Simultaneous ALU writes, forwarded or registered
        @(posedge clk); #1;
        bus.we_hi = 1'b1; bus.hi_wdata = 32'hDEAD_BEEF;
        bus.we_lo = 1'b1; bus.lo_wdata = 32'h1234_5678;
        #1;
`ifdef HILO_BYPASS_EN
        chk("wr_same_hi", bus.hi_out, 32'hDEAD_BEEF);
        chk("wr_same_lo", bus.lo_out, 32'h1234_5678);
`else
        chk("wr_same_hi", bus.hi_out, 32'd0);
        chk("wr_same_lo", bus.lo_out, 32'd0);
`endif
        @(posedge clk); #1;
        bus.we_hi = 1'b0; bus.we_lo = 1'b0;
        #1;
        mhi = 32'hDEAD_BEEF; mlo = 32'h1234_5678;
        chk("wr_next_hi", bus.hi_out, mhi);
        chk("wr_next_lo", bus.lo_out, mlo);

        // Reset in the middle of a division
        @(posedge clk); #1;
        bus.div_start = 1'b1; bus.div_signed = 1'b0;
        bus.div_a = 32'd100; bus.div_b = 32'd7;
        @(posedge clk); #1;
        bus.div_start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        mhi = 32'd0; mlo = 32'd0;
        chk("midrst_hi", bus.hi_out, 32'd0);
        chk("midrst_lo", bus.lo_out, 32'd0);
        chk("midrst_busy", 32'(bus.div_busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (bus.div_done || bus.div_busy) seen = 1'b1;
        end
        chk("midrst_idle", 32'(seen), 32'd0);
        chk("midrst_hi_after", bus.hi_out, 32'd0);

        // Directed divide table
        for (int i = 0; i < 11; i++) begin
            run_div(tbl[i].sgn, tbl[i].a, tbl[i].b, tbl[i].q, tbl[i].r, -1, -1, 1'b0);
        end

        // Flush at RUN cycle 5 of a divide following DIVU 0x1234/0
        run_div(1'b0, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 32'h0000_1234, -1, -1, 1'b0);
        run_div(1'b0, 32'd500, 32'd3, 32'd0, 32'd0, 5, -1, 1'b0);

        // ALU LO write in the DONE cycle loses to the divider
        run_div(1'b0, 32'd9, 32'd4, 32'd2, 32'd1, -1, -1, 1'b1);

        // div_start during RUN is ignored
        run_div(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, -1, 3, 1'b0);

        // flush in IDLE suppresses div_start
        @(posedge clk); #1;
        bus.div_start = 1'b1; bus.flush = 1'b1;
        bus.div_a = 32'd50; bus.div_b = 32'd5;
        @(posedge clk); #1;
        bus.div_start = 1'b0; bus.flush = 1'b0;
        #1;
        chk("idle_flush_busy", 32'(bus.div_busy), 32'd0);
        seen = 1'b0;
        repeat (36) begin
            @(negedge clk);
            if (bus.div_done) seen = 1'b1;
        end
        chk("idle_flush_no_done", 32'(seen), 32'd0);
        chk("idle_flush_lo", bus.lo_out, mlo);

        // Random divides against the reference model
        for (int n = 0; n < 30; n++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1, 2:    b = 32'($urandom_range(1, 15));
                3:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
                default: b = $urandom;
            endcase
            ref_div(sgn, a, b, q, r);
            run_div(sgn, a, b, q, r, -1, -1, 1'b0);
        end

        // Random ALU writes against the reference model
        for (int n = 0; n < 16; n++) begin
            @(posedge clk); #1;
            bus.we_hi = 1'($urandom_range(0, 1));
            bus.we_lo = 1'($urandom_range(0, 1));
            bus.hi_wdata = $urandom;
            bus.lo_wdata = $urandom;
            #1;
`ifdef HILO_BYPASS_EN
            exp_hi = bus.we_hi ? bus.hi_wdata : mhi;
            exp_lo = bus.we_lo ? bus.lo_wdata : mlo;
`else
            exp_hi = mhi;
            exp_lo = mlo;
`endif
            chk("rnd_wr_hi", bus.hi_out, exp_hi);
            chk("rnd_wr_lo", bus.lo_out, exp_lo);
            if (bus.we_hi) mhi = bus.hi_wdata;
            if (bus.we_lo) mlo = bus.lo_wdata;
        end
        @(posedge clk); #1;
        bus.we_hi = 1'b0; bus.we_lo = 1'b0;
        #1;
        chk("rnd_final_hi", bus.hi_out, mhi);
        chk("rnd_final_lo", bus.lo_out, mlo);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hilo_div_unit.md
Name: hilo_div_unit

Overview:
- Owns the architectural HI/LO register pair of the MIPS core.
- Accepts HI/LO writes from the ALU path (MULT/MULTU/MADD/MSUB/MTHI/MTLO results) at writeback.
- Drives the ALU's hi_in/lo_in read operands.
- Contains an iterative radix-2 divider for DIV/DIVU, which stalls the pipeline while running and writes HI = remainder, LO = quotient on completion.

Parameters:
- WIDTH, 32: data width of HI, LO and the divider operands.

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- we_hi  input  1  write HI from the ALU path this cycle.
- we_lo  input  1  write LO from the ALU path this cycle.
- hi_wdata  input  WIDTH  ALU HI write data (hi_alu_out).
- lo_wdata  input  WIDTH  ALU LO write data (lo_alu_out).
- div_start  input  1  request a division; sampled only in IDLE.
- div_signed  input  1  1 = DIV (signed), 0 = DIVU; sampled with div_start.
- div_a  input  WIDTH  dividend; sampled with div_start.
- div_b  input  WIDTH  divisor; sampled with div_start.
- flush  input  1  exception/flush; aborts a running division.
- hi_out  output  WIDTH  HI read value to the ALU hi_in.
- lo_out  output  WIDTH  LO read value to the ALU lo_in.
- div_busy  output  1  stall request to the pipeline.
- div_done  output  1  one-cycle pulse in the DONE state.

Behaviour:
- Reset, asynchronous: HI = 0, LO = 0, state = IDLE, iteration counter = 0, div_busy = 0, div_done = 0.
- States: IDLE, RUN, DONE.
- IDLE -> RUN when div_start = 1 and flush = 0.
  - Latch |a| and |b| (signed mode) or raw a and b.
  - Latch the quotient sign (a[31] ^ b[31]) and remainder sign (a[31]).
  - Clear the counter.
- RUN: one restoring step per cycle; 32 cycles total.
  - Counter 0..31; RUN -> DONE after the step with counter = 31.
- DONE: lasts exactly 1 cycle, then -> IDLE.
  - div_done = 1.
  - Apply sign fixups: negate the quotient if the quotient sign is set; negate the remainder if the remainder sign is set.
  - At the closing edge: HI <= remainder, LO <= quotient.
- Latency: start sampled at edge E0; DONE is the cycle after edge E32; results are architecturally visible after edge E33.
- div_busy = (IDLE & div_start) | RUN. It is combinational so the DIV instruction stalls in the same cycle; it is 0 in DONE so the instruction advances.
- Divisor = 0, no trap:
  - LO = all ones, HI = dividend (unsigned magnitude path).
  - Signed sign fixup still applies.
- Signed 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0, no trap.
- Write priority in the same cycle:
  - Divider DONE write beats we_hi/we_lo.
  - Otherwise we_hi and we_lo write independently.
- flush:
  - In RUN or DONE: -> IDLE with no HI/LO write and no div_done.
  - In IDLE: suppresses a same-cycle div_start.
  - flush does not block we_hi/we_lo; the pipeline gates those itself.
- div_start while in RUN or DONE is ignored.
- hi_out/lo_out: registered HI/LO, modified by the bypass rules below.

Optional Feature:
- Macro: HILO_BYPASS_EN.
- Defined:
  - hi_out = hi_wdata when we_hi = 1, else HI; lo_out likewise.
  - In DONE, hi_out/lo_out show the pending remainder/quotient (divider result has priority).
  - Gives same-cycle write-to-read forwarding for MFHI/MFLO and MADD accumulation.
- Undefined:
  - hi_out/lo_out are the registered values only.
  - The hazard unit must stall one cycle on HI/LO RAW.

Decomposition:
- Shared defines header:
  - State encodings DIV_IDLE = 2'b00, DIV_RUN = 2'b01, DIV_DONE = 2'b10.
  - DIV_CYCLES = 32.
- One sub-module, div_core:
  - Contains the magnitude shift/subtract datapath and counter.
  - Inputs: start, operands, flush. Outputs: quotient, remainder, last-step flag.
- hilo_div_unit keeps the FSM, sign handling, HI/LO registers and bypass.

Test Plan:
- Reset mid-RUN (start 100/7, assert rst at cycle 10) -> HI = LO = 0, div_busy = 0 immediately; state IDLE.
- DIVU 7/2 started at E0 -> div_busy high from start through RUN; div_done in cycle 33; afterwards LO = 3, HI = 1.
- DIV 0xFFFFFFF9 (-7) / 2 -> LO = 0xFFFFFFFD, HI = 0xFFFFFFFF; then DIV 0x80000000 / 0xFFFFFFFF -> LO = 0x80000000, HI = 0.
- DIVU 0x1234 / 0 -> LO = 0xFFFFFFFF, HI = 0x1234; flush at RUN cycle 5 of a second divide -> no write, no div_done, HI/LO unchanged.
- we_hi = 1 with 0xDEADBEEF, we_lo = 1 with 0x12345678 in the same cycle -> with HILO_BYPASS_EN, hi_out/lo_out show them the same cycle; without it, the following cycle.
- we_lo = 1 with 0x5 during the DONE cycle of 9/4 -> LO = 2 (divider wins), HI = 1.
